seg_msg_scheduler: RTL

Arbitrates the 8-digit seven-segment frame between a persistent background frame (mode banner) and up to NREQ one-shot timed messages (error, bonus result, opcode confirm).
- Grants requesters by fixed priority, holds each message for a requested duration with optional blink, then restores the background.
- Output frame_out feeds the existing scan driver, which remains purely a display multiplexer.

---
 rtl/seg_msg_scheduler.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/seg_msg_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : seg_msg_scheduler
//  Purpose  : Chooses which 64-bit frame the 8-digit seven-segment scan
//             driver shows. A persistent background frame is normally shown.
//             Up to NREQ timed messages can replace it, granted by fixed
//             priority (index 0 highest). Each message can blink, is held for
//             a requested number of ticks, and is followed by a short
//             background gap.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   system clock
//    rst        in   synchronous reset, active-high
//    base_frame in   background frame, digit k at [8k+7:8k]
//    req        in   level request, one bit per requester
//    req_frame  in   message frame, requester i at [64i+63:64i]
//    req_dur    in   duration in ticks, requester i at [16i+15:16i] (0 = hold)
//    req_blink  in   blink enable, one bit per requester
//    cancel     in   drop the message currently shown
//    ack        out  one-cycle one-hot grant pulse
//    frame_out  out  registered frame for the scan driver
//    busy       out  high while a message or the following gap is active
//    active_id  out  index of the message being shown (held when idle)
// ============================================================================
module seg_msg_scheduler #(
  parameter int NREQ        = 3,
  parameter int TICK_DIV    = 100000,
  parameter int GAP_TICKS   = 50,
  parameter int BLINK_TICKS = 250
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [63:0]          base_frame,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*64-1:0]   req_frame,
  input  logic [NREQ*16-1:0]   req_dur,
  input  logic [NREQ-1:0]      req_blink,
  input  logic                 cancel,
  output logic [NREQ-1:0]      ack,
  output logic [63:0]          frame_out,
  output logic                 busy,
  output logic [1:0]           active_id
);

  localparam int              PW           = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   C_PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [15:0]     C_BLINK_LAST = 16'(BLINK_TICKS - 1);
  localparam logic [15:0]     C_GAP_LOAD   = 16'(GAP_TICKS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SHOW = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [63:0]       frame_q, frame_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic              busy_q, busy_d;
  logic [1:0]        id_q, id_d;
  logic [63:0]       msg_q, msg_d;
  logic              blink_en_q, blink_en_d;
  logic              hold_q, hold_d;      // duration 0: show until cancel/preempt
  logic [15:0]       dur_q, dur_d;        // remaining ticks of the message
  logic [15:0]       gap_q, gap_d;        // remaining ticks of the gap
  logic              vis_q, vis_d;        // blink phase: 1 = message visible
  logic [15:0]       bcnt_q, bcnt_d;      // ticks into current blink half-period
  logic [PW-1:0]     presc_q, presc_d;

  logic              w_tick;
  logic              w_any;
  logic [1:0]        w_gidx;
  logic [63:0]       w_gframe;
  logic [15:0]       w_gdur;
  logic              w_gblink;
  logic              w_grant;

  assign w_tick = (presc_q == C_PRESC_LAST);

  // Lowest set request index wins; its frame/duration/blink are muxed out.
  always_comb begin
    w_gidx   = '0;
    w_any    = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        w_gidx = 2'(i);
        w_any  = 1'b1;
      end
    end
    w_gframe = '0;
    w_gdur   = '0;
    w_gblink = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gidx == 2'(i)) begin
        w_gframe = req_frame[64*i +: 64];
        w_gdur   = req_dur[16*i +: 16];
        w_gblink = req_blink[i];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    ack_d      = '0;
    id_d       = id_q;
    msg_d      = msg_q;
    blink_en_d = blink_en_q;
    hold_d     = hold_q;
    dur_d      = dur_q;
    gap_d      = gap_q;
    vis_d      = vis_q;
    bcnt_d     = bcnt_q;
    presc_d    = w_tick ? '0 : presc_q + 1'b1;
    w_grant    = 1'b0;

    case (state_q)
      S_IDLE: begin
        frame_d = base_frame;
        w_grant = w_any;
      end

      S_SHOW: begin
        if (cancel) begin
          // Frame is left as-is for this edge; IDLE reloads the background.
          state_d = S_IDLE;
        end else if (w_any && (w_gidx < id_q)) begin
          w_grant = 1'b1;
        end else begin
          if (w_tick && blink_en_q) begin
            if (bcnt_q == C_BLINK_LAST) begin
              bcnt_d = '0;
              vis_d  = ~vis_q;
            end else begin
              bcnt_d = bcnt_q + 16'd1;
            end
          end
          frame_d = vis_d ? msg_q : 64'h0;
          if (w_tick && !hold_q) begin
            // Compare against 1 so a zero count can never wrap.
            if (dur_q <= 16'd1) begin
              dur_d   = '0;
              frame_d = base_frame;
              if (GAP_TICKS > 0) begin
                state_d = S_GAP;
                gap_d   = C_GAP_LOAD;
                presc_d = '0;
              end else begin
                state_d = S_IDLE;
              end
            end else begin
              dur_d = dur_q - 16'd1;
            end
          end
        end
      end

      S_GAP: begin
        frame_d = base_frame;
        if (w_tick) begin
          if (gap_q <= 16'd1) begin
            gap_d   = '0;
            state_d = S_IDLE;
          end else begin
            gap_d = gap_q - 16'd1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A grant (from IDLE or as a preempt) restarts every timer.
    if (w_grant) begin
      state_d    = S_SHOW;
      for (int i = 0; i < NREQ; i++) begin
        ack_d[i] = (w_gidx == 2'(i));
      end
      id_d       = w_gidx;
      msg_d      = w_gframe;
      frame_d    = w_gframe;
      dur_d      = w_gdur;
      hold_d     = (w_gdur == 16'd0);
      blink_en_d = w_gblink;
      vis_d      = 1'b1;
      bcnt_d     = '0;
      presc_d    = '0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      frame_q    <= '0;
      ack_q      <= '0;
      busy_q     <= 1'b0;
      id_q       <= '0;
      msg_q      <= '0;
      blink_en_q <= 1'b0;
      hold_q     <= 1'b0;
      dur_q      <= '0;
      gap_q      <= '0;
      vis_q      <= 1'b1;
      bcnt_q     <= '0;
      presc_q    <= '0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      id_q       <= id_d;
      msg_q      <= msg_d;
      blink_en_q <= blink_en_d;
      hold_q     <= hold_d;
      dur_q      <= dur_d;
      gap_q      <= gap_d;
      vis_q      <= vis_d;
      bcnt_q     <= bcnt_d;
      presc_q    <= presc_d;
    end
  end

  assign ack       = ack_q;
  assign frame_out = frame_q;
  assign busy      = busy_q;
  assign active_id = id_q;

endmodule
`default_nettype wire
